// File: rtl/alu_issue_ctrl.sv
// Issue sequencer that sits between instruction decode and a combinational ALU.
// It holds the operands on the ALU for an op-dependent settle time and then registers the result for a valid/ready consumer.
module alu_issue_ctrl #(
    parameter int WIDTH    = 3,
    parameter int LAT_SUM  = 1,
    parameter int LAT_MULT = 2,
    parameter int LAT_DIV  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_a,
    input  logic [WIDTH:0]   in_b,
    input  logic [1:0]       in_op,
    input  logic             in_ci,
    output logic [WIDTH:0]   alu_a,
    output logic [WIDTH:0]   alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_ci,
    input  logic [WIDTH:0]   alu_out,
    input  logic [3:0]       alu_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic             sticky_err,
    input  logic             clr_err
);

    localparam int LAT_MAX_AM = (LAT_SUM > LAT_MULT) ? LAT_SUM : LAT_MULT;
    localparam int LAT_MAX    = (LAT_MAX_AM > LAT_DIV) ? LAT_MAX_AM : LAT_DIV;
    localparam int CNT_W      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_latInit;
    logic               w_accept;
    logic               w_illegal;
    logic               w_cntZero;

    logic [WIDTH:0]     r_aluA;
    logic [WIDTH:0]     r_aluB;
    logic [1:0]         r_aluOp;
    logic               r_aluCi;
    logic [WIDTH:0]     r_outResult;
    logic [3:0]         r_outFlags;
    logic               r_outErr;
    logic               r_stickyErr;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_illegal = (in_op == 2'b11) || ((in_op == 2'b10) && (in_b == '0));
    assign w_cntZero = (r_cnt == '0);

    always_comb begin
        w_latInit = '0;
        case (in_op)
            2'b00:   w_latInit = CNT_W'(LAT_SUM - 1);
            2'b01:   w_latInit = CNT_W'(LAT_MULT - 1);
            default: w_latInit = CNT_W'(LAT_DIV - 1);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Illegal ops skip the settle phase entirely and present their error result at once.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_illegal ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (w_cntZero) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_aluOp     <= '0;
            r_aluCi     <= 1'b0;
            r_cnt       <= '0;
            r_outResult <= '0;
            r_outFlags  <= '0;
            r_outErr    <= 1'b0;
        end else if (w_accept) begin
            r_aluA  <= in_a;
            r_aluB  <= in_b;
            r_aluOp <= in_op;
            r_aluCi <= in_ci;
            r_cnt   <= w_latInit;
            if (w_illegal) begin
                r_outResult <= '0;
                r_outFlags  <= '0;
                r_outErr    <= 1'b1;
            end
        end else if (r_state == EXEC) begin
            if (w_cntZero) begin
                r_outResult <= alu_out;
                r_outFlags  <= alu_flags;
                r_outErr    <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // A new illegal op outranks a simultaneous clear so the error is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stickyErr <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_stickyErr <= 1'b1;
        end else if (clr_err) begin
            r_stickyErr <= 1'b0;
        end
    end

    assign alu_a      = r_aluA;
    assign alu_b      = r_aluB;
    assign alu_op     = r_aluOp;
    assign alu_ci     = r_aluCi;
    assign out_result = r_outResult;
    assign out_flags  = r_outFlags;
    assign out_err    = r_outErr;
    assign sticky_err = r_stickyErr;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives the DUT's ALU port, and each scenario
// compares the DUT against expectations derived from the issued operands.
module tb_alu_issue_ctrl;

    localparam int LAT_SUM  = 1;
    localparam int LAT_MULT = 2;
    localparam int LAT_DIV  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [3:0] inA = '0;
    logic [3:0] inB = '0;
    logic [1:0] inOp = '0;
    logic       inCi = 1'b0;
    logic [3:0] aluA;
    logic [3:0] aluB;
    logic [1:0] aluOp;
    logic       aluCi;
    logic [3:0] aluOut;
    logic [3:0] aluFlags;
    logic       outValid;
    logic       outReady = 1'b0;
    logic [3:0] outResult;
    logic [3:0] outFlags;
    logic       outErr;
    logic       stickyErr;
    logic       clrErr = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    alu_issue_ctrl #(
        .WIDTH(3), .LAT_SUM(LAT_SUM), .LAT_MULT(LAT_MULT), .LAT_DIV(LAT_DIV)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady),
        .in_a(inA), .in_b(inB), .in_op(inOp), .in_ci(inCi),
        .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp), .alu_ci(aluCi),
        .alu_out(aluOut), .alu_flags(aluFlags),
        .out_valid(outValid), .out_ready(outReady),
        .out_result(outResult), .out_flags(outFlags), .out_err(outErr),
        .sticky_err(stickyErr), .clr_err(clrErr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {result, N, Z, C, V} with the result truncated to 4 bits.
    function automatic logic [7:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op, input logic ci);
        int s;
        logic [3:0] r;
        logic c;
        logic v;
        s = 0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'd0: begin
                s = int'(a) + int'(b) + int'(ci);
                r = 4'(s);
                c = (s > 15);
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            2'd1: begin
                s = int'(a) * int'(b);
                r = 4'(s);
                c = (s > 15);
            end
            2'd2: begin
                if (b != 4'd0) r = 4'(int'(a) / int'(b));
            end
            default: r = '0;
        endcase
        return {r, r[3], (r == 4'd0), c, v};
    endfunction

    function automatic int latencyOf(input logic [1:0] op, input logic [3:0] b);
        if (op == 2'd3 || (op == 2'd2 && b == 4'd0)) return 0;
        if (op == 2'd0) return LAT_SUM;
        if (op == 2'd1) return LAT_MULT;
        return LAT_DIV;
    endfunction

    assign {aluOut, aluFlags} = aluModel(aluA, aluB, aluOp, aluCi);

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] op, input logic ci);
        @(negedge clk);
        inValid = 1'b1;
        inA = a;
        inB = b;
        inOp = op;
        inCi = ci;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitValid(output int edges);
        edges = 0;
        while (!outValid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        testsRun++;
        if (inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady);
        end
        testsRun++;
        if ({aluA, aluB, aluOp, aluCi, outValid, outResult, outFlags, outErr, stickyErr} !== 24'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {aluA, aluB, aluOp, aluCi, outValid, outResult, outFlags, outErr, stickyErr});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int edges;
        applyStimulus(4'd7, 4'd9, 2'd0, 1'b0);
        testsRun++;
        if ({aluA, aluB, aluOp, aluCi} !== {4'd7, 4'd9, 2'd0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL add_alu_inputs: got %h expected %h", {aluA, aluB, aluOp, aluCi}, {4'd7, 4'd9, 2'd0, 1'b0});
        end
        waitValid(edges);
        testsRun++;
        if (edges !== 1) begin
            testsFailed++;
            $display("[TB] FAIL add_latency: got %0d expected 1", edges);
        end
        testsRun++;
        if ({outResult, outFlags, outErr} !== {4'd0, 4'b0110, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL add_result: got %h expected %h", {outResult, outFlags, outErr}, {4'd0, 4'b0110, 1'b0});
        end
        consume();
    endtask

    task automatic test_mult();
        int edges;
        applyStimulus(4'd3, 4'd5, 2'd1, 1'b0);
        testsRun++;
        if (inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mult_in_ready: got %b expected 0", inReady);
        end
        waitValid(edges);
        testsRun++;
        if (edges !== 2) begin
            testsFailed++;
            $display("[TB] FAIL mult_latency: got %0d expected 2", edges);
        end
        testsRun++;
        if (outResult !== 4'd15 || outFlags[2] !== 1'b0 || outErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mult_result: got %0d Z=%b err=%b expected 15 Z=0 err=0", outResult, outFlags[2], outErr);
        end
        consume();
    endtask

    task automatic test_div();
        applyStimulus(4'd9, 4'd2, 2'd2, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            testsRun++;
            if (inReady !== 1'b0 || outValid !== (i == 4)) begin
                testsFailed++;
                $display("[TB] FAIL div_timing_%0d: got in_ready=%b out_valid=%b expected 0/%b", i, inReady, outValid, (i == 4));
            end
        end
        testsRun++;
        if (outResult !== 4'd4 || outErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL div_result: got %0d err=%b expected 4 err=0", outResult, outErr);
        end
        consume();
    endtask

    task automatic test_illegal();
        applyStimulus(4'd5, 4'd3, 2'd3, 1'b1);
        testsRun++;
        if ({outValid, outResult, outFlags, outErr, stickyErr, aluOp} !== {1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 2'd3}) begin
            testsFailed++;
            $display("[TB] FAIL illegal_op11: got %h expected %h",
                     {outValid, outResult, outFlags, outErr, stickyErr, aluOp}, {1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 2'd3});
        end
        consume();
        applyStimulus(4'd6, 4'd0, 2'd2, 1'b0);
        testsRun++;
        if ({outValid, outResult, outFlags, outErr, stickyErr, aluA} !== {1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6}) begin
            testsFailed++;
            $display("[TB] FAIL illegal_div0: got %h expected %h",
                     {outValid, outResult, outFlags, outErr, stickyErr, aluA}, {1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6});
        end
        consume();
        @(negedge clk);
        inValid = 1'b1;
        inOp = 2'd3;
        clrErr = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        clrErr = 1'b0;
        testsRun++;
        if (stickyErr !== 1'b1 || outErr !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL illegal_set_wins: got sticky=%b err=%b expected 1/1", stickyErr, outErr);
        end
        consume();
        @(negedge clk);
        clrErr = 1'b1;
        @(posedge clk);
        #1;
        clrErr = 1'b0;
        testsRun++;
        if (stickyErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sticky_clear: got %b expected 0", stickyErr);
        end
    endtask

    task automatic test_backpressure();
        int edges;
        applyStimulus(4'd2, 4'd3, 2'd0, 1'b1);
        waitValid(edges);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            testsRun++;
            if ({outValid, inReady, outResult, outFlags, outErr, aluA, aluB, aluOp, aluCi} !==
                {1'b1, 1'b0, 4'd6, 4'b0000, 1'b0, 4'd2, 4'd3, 2'd0, 1'b1}) begin
                testsFailed++;
                $display("[TB] FAIL backpressure_hold_%0d: got %h expected %h", i,
                         {outValid, inReady, outResult, outFlags, outErr, aluA, aluB, aluOp, aluCi},
                         {1'b1, 1'b0, 4'd6, 4'b0000, 1'b0, 4'd2, 4'd3, 2'd0, 1'b1});
            end
        end
        consume();
        testsRun++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_release: got in_ready=%b out_valid=%b expected 1/0", inReady, outValid);
        end
    endtask

    task automatic test_reset_mid_exec();
        int edges;
        applyStimulus(4'd9, 4'd2, 2'd2, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if (inReady !== 1'b1 ||
            {aluA, aluB, aluOp, aluCi, outValid, outResult, outFlags, outErr, stickyErr} !== 24'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_exec: got in_ready=%b outs=%h expected 1/0", inReady,
                     {aluA, aluB, aluOp, aluCi, outValid, outResult, outFlags, outErr, stickyErr});
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'd1, 4'd1, 2'd0, 1'b0);
        waitValid(edges);
        testsRun++;
        if (edges !== 1 || outResult !== 4'd2 || outErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_add: got lat=%0d res=%0d err=%b expected 1/2/0", edges, outResult, outErr);
        end
        consume();
    endtask

    task automatic test_random();
        int edges;
        int expLat;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic ci;
        logic illegal;
        logic expSticky;
        logic [8:0] expOut;
        @(negedge clk);
        clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
        expSticky = 1'b0;
        for (int n = 0; n < 40; n++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            ci = 1'($urandom_range(0, 1));
            if (op == 2'd2 && $urandom_range(0, 3) == 0) b = 4'd0;
            illegal = (op == 2'd3) || (op == 2'd2 && b == 4'd0);
            expSticky = expSticky | illegal;
            expLat = latencyOf(op, b);
            expOut = illegal ? {4'd0, 4'd0, 1'b1} : {aluModel(a, b, op, ci), 1'b0};
            applyStimulus(a, b, op, ci);
            waitValid(edges);
            testsRun++;
            if (edges !== expLat) begin
                testsFailed++;
                $display("[TB] FAIL rand_latency_%0d: got %0d expected %0d (op=%0d b=%0d)", n, edges, expLat, op, b);
            end
            testsRun++;
            if ({outResult, outFlags, outErr} !== expOut) begin
                testsFailed++;
                $display("[TB] FAIL rand_result_%0d: got %h expected %h (a=%0d b=%0d op=%0d ci=%b)",
                         n, {outResult, outFlags, outErr}, expOut, a, b, op, ci);
            end
            testsRun++;
            if (stickyErr !== expSticky) begin
                testsFailed++;
                $display("[TB] FAIL rand_sticky_%0d: got %b expected %b", n, stickyErr, expSticky);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mult();
        test_div();
        test_illegal();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
